// File: rtl/data_sync_tx_pkg.sv
// Shared definitions for the source-side bus-synchronizer launcher.
// Holds the FSM state encoding and the minimum legal parameter values.
// No logic lives here; it is imported by the launcher and its synchronizer.
package data_sync_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REQ     = 2'b01,
    ST_RELEASE = 2'b10
  } state_t;

  // Below these the crossing cannot guarantee a stable sample at the receiver.
  localparam int MIN_HOLD_CYCLES = 2;
  localparam int MIN_NUM_STAGES  = 2;

endpackage

// File: rtl/data_sync_tx_bit_sync.sv
// Single-bit multi-flop synchronizer into the i_clk domain.
// Latency: NUM_STAGES i_clk edges from i_d to o_q.
// Backpressure: none; pulses shorter than the sync depth may be lost.
module bit_sync
  import data_sync_tx_pkg::*;
#(
  parameter int NUM_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [NUM_STAGES-1:0] r_sync;

  if (NUM_STAGES < MIN_NUM_STAGES) begin : g_bad_stages
    $error("bit_sync: NUM_STAGES must be at least %0d", MIN_NUM_STAGES);
  end

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[NUM_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_tx.sv
// Source-domain launcher: registers a word onto unsync_bus and raises bus_enable.
// Latency: bus_enable/unsync_bus valid one cycle after the accept edge.
// Backpressure: src_ready only in IDLE (and no stale ack); no buffering.
module data_sync_tx
  import data_sync_tx_pkg::*;
#(
  parameter int BUS_WIDTH   = 8,
  parameter int NUM_STAGES  = 2,
  parameter int ACK_EN      = 1,
  parameter int HOLD_CYCLES = 6
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] src_data,
  input  logic                 src_valid,
  output logic                 src_ready,
  input  logic                 bus_ack,
  output logic [BUS_WIDTH-1:0] unsync_bus,
  output logic                 bus_enable,
  output logic                 busy,
  output logic                 done_pulse
);

  localparam int             CNT_W     = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic           CLOSED    = (ACK_EN != 0);

  if (HOLD_CYCLES < MIN_HOLD_CYCLES || NUM_STAGES < MIN_NUM_STAGES) begin : g_bad_params
    $error("data_sync_tx: HOLD_CYCLES >= %0d and NUM_STAGES >= %0d required",
           MIN_HOLD_CYCLES, MIN_NUM_STAGES);
  end

  state_t                 r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [BUS_WIDTH-1:0]   r_bus;
  logic                   r_en, w_en_nxt;
  logic                   r_done, w_done_nxt;
  logic                   w_load;
  logic                   w_ack_sync;
  logic                   w_idle_rdy;
  logic                   w_accept;

  bit_sync #(.NUM_STAGES(NUM_STAGES)) u_ack_sync (
    .i_clk  (CLK),
    .i_rst_n(RST),
    .i_d    (bus_ack),
    .o_q    (w_ack_sync)
  );

  // A stale ack still high from the previous transfer blocks a new request.
  assign w_idle_rdy = CLOSED ? !w_ack_sync : 1'b1;
  assign src_ready  = RST && (r_state == ST_IDLE) && w_idle_rdy;
  assign w_accept   = src_valid && src_ready;

  // Next-state, hold counter, enable and completion pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_en_nxt    = r_en;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_load      = 1'b1;
          w_en_nxt    = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        w_en_nxt = 1'b1;
        if (CLOSED) begin
          if (w_ack_sync) begin
            w_en_nxt    = 1'b0;
            w_state_nxt = ST_RELEASE;
          end
        end else if (r_cnt == HOLD_LAST) begin
          w_en_nxt    = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_RELEASE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_RELEASE: begin
        w_en_nxt = 1'b0;
        if (CLOSED) begin
          if (!w_ack_sync) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else if (r_cnt == HOLD_LAST) begin
          w_done_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_en_nxt    = 1'b0;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register and hold counter.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Registered outputs toward the receiver; the word only moves on accept.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_bus  <= '0;
      r_en   <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (w_load) begin
        r_bus <= src_data;
      end
      r_en   <= w_en_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign unsync_bus = r_bus;
  assign bus_enable = r_en;
  assign busy       = (r_state != ST_IDLE);
  assign done_pulse = r_done;

endmodule

// File: tb/tb_data_sync_tx.sv
module tb_data_sync_tx;

  localparam int NS   = 2;
  localparam int HOLD = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] v_data  [2];
  logic       v_valid [2];
  logic       v_ack   [2];
  logic       o_rdy   [2];
  logic [7:0] o_bus   [2];
  logic       o_en    [2];
  logic       o_busy  [2];
  logic       o_done  [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Instance 0: closed-loop handshake. Instance 1: open-loop timed.
  data_sync_tx #(.BUS_WIDTH(8), .NUM_STAGES(NS), .ACK_EN(1), .HOLD_CYCLES(HOLD)) u_closed (
    .CLK(clk), .RST(rst_n), .src_data(v_data[0]), .src_valid(v_valid[0]), .src_ready(o_rdy[0]),
    .bus_ack(v_ack[0]), .unsync_bus(o_bus[0]), .bus_enable(o_en[0]), .busy(o_busy[0]),
    .done_pulse(o_done[0]));

  data_sync_tx #(.BUS_WIDTH(8), .NUM_STAGES(NS), .ACK_EN(0), .HOLD_CYCLES(HOLD)) u_open (
    .CLK(clk), .RST(rst_n), .src_data(v_data[1]), .src_valid(v_valid[1]), .src_ready(o_rdy[1]),
    .bus_ack(v_ack[1]), .unsync_bus(o_bus[1]), .bus_enable(o_en[1]), .busy(o_busy[1]),
    .done_pulse(o_done[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  // phase 0 = waiting for a word, 1 = request raised, 2 = request dropped
  int         m_phase [2];
  int         m_rem   [2];
  logic [7:0] m_bus   [2];
  logic       m_done  [2];
  logic [NS-1:0] m_hist [2];  // bus_ack samples, newest in bit 0

  function automatic logic exp_rdy(int d);
    return (m_phase[d] == 0) && (d == 1 || !m_hist[d][NS-1]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_phase[d] <= 0;
        m_rem[d]   <= 0;
        m_bus[d]   <= '0;
        m_done[d]  <= 1'b0;
        m_hist[d]  <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_hist[d] <= {m_hist[d][NS-2:0], v_ack[d]};
        m_done[d] <= 1'b0;
        case (m_phase[d])
          0: if (v_valid[d] && exp_rdy(d)) begin
               m_bus[d]   <= v_data[d];
               m_phase[d] <= 1;
               m_rem[d]   <= HOLD;
             end
          1: if (d == 0) begin
               if (m_hist[d][NS-1]) m_phase[d] <= 2;
             end else if (m_rem[d] == 1) begin
               m_phase[d] <= 2;
               m_rem[d]   <= HOLD;
             end else begin
               m_rem[d] <= m_rem[d] - 1;
             end
          default: if (d == 0) begin
               if (!m_hist[d][NS-1]) begin
                 m_phase[d] <= 0;
                 m_done[d]  <= 1'b1;
               end
             end else if (m_rem[d] == 1) begin
               m_phase[d] <= 0;
               m_done[d]  <= 1'b1;
             end else begin
               m_rem[d] <= m_rem[d] - 1;
             end
        endcase
      end
    end
  end

  // Compare every DUT output to the model on each falling edge out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("model_d%0d_bus_enable", d), 32'(o_en[d]),   32'(m_phase[d] == 1));
        chk($sformatf("model_d%0d_busy", d),       32'(o_busy[d]), 32'(m_phase[d] != 0));
        chk($sformatf("model_d%0d_done", d),       32'(o_done[d]), 32'(m_done[d]));
        chk($sformatf("model_d%0d_unsync_bus", d), 32'(o_bus[d]),  32'(m_bus[d]));
        chk($sformatf("model_d%0d_src_ready", d),  32'(o_rdy[d]),  32'(exp_rdy(d)));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int n, hi, lo;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      v_data[d] = '0; v_valid[d] = 1'b0; v_ack[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_d%0d_bus_enable", d), 32'(o_en[d]), 0);
      chk($sformatf("rst_d%0d_busy", d),       32'(o_busy[d]), 0);
      chk($sformatf("rst_d%0d_done", d),       32'(o_done[d]), 0);
      chk($sformatf("rst_d%0d_unsync_bus", d), 32'(o_bus[d]), 0);
      chk($sformatf("rst_d%0d_src_ready", d),  32'(o_rdy[d]), 0);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready_closed", 32'(o_rdy[0]), 1);
    chk("post_rst_ready_open",   32'(o_rdy[1]), 1);

    // Closed-loop transfer of A5.
    tick();
    v_data[0] = 8'hA5; v_valid[0] = 1'b1;
    tick();
    v_valid[0] = 1'b0;
    chk("a5_bus_enable", 32'(o_en[0]), 1);
    chk("a5_unsync_bus", 32'(o_bus[0]), 32'h A5);
    chk("a5_src_ready",  32'(o_rdy[0]), 0);
    chk("a5_busy",       32'(o_busy[0]), 1);
    v_ack[0] = 1'b1;
    n = 0;
    while (o_en[0] && n < 20) begin tick(); n++; end
    chk("a5_ack_to_enable_fall", 32'(n), NS + 1);
    v_ack[0] = 1'b0;
    n = 0;
    while (!o_done[0] && n < 20) begin tick(); n++; end
    chk("a5_ackfall_to_done", 32'(n), NS + 1);
    chk("a5_bus_held", 32'(o_bus[0]), 32'h A5);

    // Open-loop transfer of 3C; bus_ack is toggled to show it is ignored.
    tick();
    v_data[1] = 8'h3C; v_valid[1] = 1'b1; v_ack[1] = 1'b1;
    tick();
    v_valid[1] = 1'b0;
    hi = 0;
    while (o_en[1] && hi < 50) begin hi++; tick(); end
    v_ack[1] = 1'b0;
    lo = 0;
    while (!o_done[1] && lo < 50) begin lo++; tick(); end
    chk("3c_enable_high_cycles", 32'(hi), HOLD);
    chk("3c_enable_low_cycles",  32'(lo), HOLD);
    chk("3c_enable_to_done",     32'(hi + lo), 2 * HOLD);
    chk("3c_bus_value",          32'(o_bus[1]), 32'h3C);

    // Back-to-back 11 then 22 with src_valid held high.
    tick();
    v_data[1] = 8'h11; v_valid[1] = 1'b1;
    tick();
    v_data[1] = 8'h22;
    n = 0;
    while (!o_done[1] && n < 50) begin n++; tick(); end
    chk("b2b_first_done_latency", 32'(n), 2 * HOLD);
    chk("b2b_ready_in_done_cycle", 32'(o_rdy[1]), 1);
    chk("b2b_bus_still_11", 32'(o_bus[1]), 32'h11);
    tick();
    v_valid[1] = 1'b0;
    chk("b2b_second_enable", 32'(o_en[1]), 1);
    chk("b2b_second_bus", 32'(o_bus[1]), 32'h22);
    n = 0;
    while (!o_done[1] && n < 50) begin n++; tick(); end
    chk("b2b_second_done_latency", 32'(n), 2 * HOLD);

    // Stale ack on the closed-loop instance.
    tick();
    v_ack[0] = 1'b1;
    repeat (3) tick();
    chk("stale_ready_low", 32'(o_rdy[0]), 0);
    v_data[0] = 8'h5A; v_valid[0] = 1'b1;
    tick();
    v_valid[0] = 1'b0;
    tick();
    chk("stale_not_busy", 32'(o_busy[0]), 0);
    chk("stale_bus_kept", 32'(o_bus[0]), 32'h A5);
    v_ack[0] = 1'b0;
    n = 0;
    while (!o_rdy[0] && n < 20) begin tick(); n++; end
    chk("stale_ready_rise_delay", 32'(n), NS);

    // Reset in the middle of an open-loop request.
    tick();
    v_data[1] = 8'h77; v_valid[1] = 1'b1;
    tick();
    v_valid[1] = 1'b0;
    tick();
    chk("midrst_enable_before", 32'(o_en[1]), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_enable", 32'(o_en[1]), 0);
    chk("midrst_busy",   32'(o_busy[1]), 0);
    chk("midrst_done",   32'(o_done[1]), 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("midrst_ready_after", 32'(o_rdy[1]), 1);
    chk("midrst_idle_after",  32'(o_busy[1]), 0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_sync_tx.md
Name: data_sync_tx

Overview:
- Source-domain launcher for the multi-bit bus synchronizer; it is the sending end of the same crossing.
- Accepts a word with a valid/ready handshake, registers it onto unsync_bus, and raises bus_enable.
- Holds bus and enable stable until the destination acknowledges (4-phase handshake), or for a fixed cycle count in open-loop mode.
- Guarantees the data is stable whenever the receiver samples it on its enable rising edge.

Parameters:
- BUS_WIDTH, 8, width of the transferred word.
- NUM_STAGES, 2, flop depth of the bus_ack synchronizer (must be >= 2).
- ACK_EN, 1, 1 = closed-loop 4-phase handshake on bus_ack; 0 = open-loop, timed by HOLD_CYCLES.
- HOLD_CYCLES, 6, open-loop only: cycles bus_enable stays high, and then cycles it stays low before the next accept. Must be >= destination NUM_STAGES+2 scaled by the clock ratio.

Ports:
- CLK  in  1  source-domain clock.
- RST  in  1  asynchronous active-low reset.
- src_data  in  BUS_WIDTH  word to send.
- src_valid  in  1  src_data is valid.
- src_ready  out  1  block can accept a word this cycle.
- bus_ack  in  1  acknowledge from the destination domain (asynchronous); ignored when ACK_EN=0.
- unsync_bus  out  BUS_WIDTH  registered data toward the receiver.
- bus_enable  out  1  registered level request toward the receiver.
- busy  out  1  a transfer is in progress (state != IDLE).
- done_pulse  out  1  one-cycle pulse when a transfer fully completes.

Behaviour:
- Reset: all outputs 0 except src_ready.
  - src_ready is 0 during reset assertion.
  - First value after reset release follows the IDLE rule below.
  - State = IDLE, ack sync flops = 0, hold counter = 0.
- ack_sync: bus_ack passed through NUM_STAGES flops on CLK. Only the last stage is used by the FSM.
- States: IDLE, REQ, RELEASE.
- IDLE:
  - src_ready = 1 when ACK_EN=0.
  - src_ready = !ack_sync when ACK_EN=1, so no new request starts while a stale ack is still high.
  - Accept = src_valid && src_ready.
  - On accept, at the same edge: unsync_bus <= src_data, bus_enable <= 1, counter <= 0, go to REQ.
  - Latency: bus_enable is high on the cycle after src_valid is sampled with src_ready.
- REQ:
  - bus_enable = 1; unsync_bus held.
  - ACK_EN=1: when ack_sync = 1, bus_enable <= 0 and go to RELEASE.
  - ACK_EN=0: counter increments each cycle; when counter == HOLD_CYCLES-1, bus_enable <= 0, counter <= 0, go to RELEASE.
- RELEASE:
  - bus_enable = 0; unsync_bus still held. It must not change until IDLE.
  - ACK_EN=1: when ack_sync = 0, go to IDLE and pulse done_pulse.
  - ACK_EN=0: when counter == HOLD_CYCLES-1, go to IDLE and pulse done_pulse.
- done_pulse: registered; high for exactly the one cycle in which state first reads IDLE after RELEASE.
- unsync_bus changes only on an accept edge. It keeps its last value in IDLE; it is not cleared.
- Simultaneous events:
  - src_valid outside IDLE is ignored (src_ready = 0); there is no buffering.
  - Back-to-back: src_ready is high in the done_pulse cycle, so an accept is allowed in that cycle.
- Glitches: a bus_ack pulse shorter than the sync depth may be missed. The protocol relies on ack being a level held by the destination, so this is acceptable.
- Reset mid-transfer: immediate return to IDLE; bus_enable drops asynchronously; no done_pulse.
- Counter width: clog2(HOLD_CYCLES+1). Elaboration error if HOLD_CYCLES < 2 or NUM_STAGES < 2.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE=2'b00, REQ=2'b01, RELEASE=2'b10);
  - the minimum HOLD_CYCLES and NUM_STAGES constants.
- Natural sub-module: bit_sync (NUM_STAGES-deep single-bit synchronizer, async active-low reset to 0). It is reused for bus_ack and for other single-bit crossings.

Test Plan:
- Reset, then ACK_EN=1: src_data=8'hA5 with src_valid=1 for one cycle.
  - Next cycle: bus_enable=1, unsync_bus=8'hA5, src_ready=0, busy=1.
- Same transfer, ack high: bus_ack driven high.
  - bus_enable falls NUM_STAGES+1 cycles later.
  - bus_ack low: done_pulse is high NUM_STAGES+1 cycles later; unsync_bus stays 8'hA5 throughout.
- ACK_EN=0, HOLD_CYCLES=6, send 8'h3C.
  - bus_enable high for exactly 6 cycles, then low 6 cycles, then done_pulse.
  - Total 12 cycles from first bus_enable=1 to done_pulse.
- Words 8'h11 and 8'h22 offered back to back with src_valid held high.
  - 8'h22 is accepted in the done_pulse cycle of 8'h11.
  - unsync_bus never changes while bus_enable=1 or in RELEASE.
- Stale ack: bus_ack held high before any request.
  - src_ready=0 and a src_valid pulse is ignored.
  - Once bus_ack falls, src_ready rises NUM_STAGES cycles later.
- RST asserted low mid-REQ with bus_enable=1.
  - bus_enable=0, busy=0, done_pulse=0 immediately.
  - After release: state IDLE, src_ready=1 (ACK_EN=0).
